// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC register, imem address, and the IF/ID pipeline register.
// The update priority on each edge is reset, then branch redirect, then the stall controls.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          PC_STEP   = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_load,
    input  logic        if_id_load,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_INC = PC_STEP[31:0];

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic [31:0] r_count;

    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;

    // With word-sized steps the low address bits of a target are meaningless, so force alignment.
    generate
        if (PC_STEP == 4) begin : g_align
            assign w_redirect_pc = {branch_target[31:2], 2'b00};
        end else begin : g_raw
            assign w_redirect_pc = branch_target;
        end
    endgenerate

    assign w_pc_inc = r_pc + PC_INC;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_instr  <= NOP_INSTR;
            r_pc_out <= 32'h0;
            r_valid  <= 1'b0;
            r_count  <= 32'h0;
        end else if (branch_taken) begin
            // Redirect beats a stall so a resolved branch is never dropped.
            r_pc     <= w_redirect_pc;
            r_instr  <= NOP_INSTR;
            r_pc_out <= r_pc;
            r_valid  <= 1'b0;
        end else begin
            if (pc_load) begin
                r_pc <= w_pc_inc;
            end
            if (if_id_load) begin
                r_instr  <= imem_data;
                r_pc_out <= r_pc;
                r_valid  <= 1'b1;
                r_count  <= r_count + 32'd1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign instruction = r_instr;
    assign pc_out      = r_pc_out;
    assign valid_out   = r_valid;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vectors with literal checks, plus a per-cycle
// comparison against an abstract fetch-stage model driven by the same inputs.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_load;
    logic        if_id_load;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [31:0] fetch_count;

    logic        ov_en;
    logic [31:0] ov_val;

    int total = 0;
    int bad   = 0;

    instruction_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .pc_load      (pc_load),
        .if_id_load   (if_id_load),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_data    (imem_data),
        .imem_addr    (imem_addr),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .valid_out    (valid_out),
        .fetch_count  (fetch_count)
    );

    always #5 clock = ~clock;

    // Instruction memory contents: two fixed words, everything else a distinct pattern.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0030_2083;
        if (a == 32'h4) return 32'h0070_2103;
        return {a[15:0], 16'h0000} ^ 32'h5A00_00B7 ^ {16'h0000, a[31:16]};
    endfunction

    assign imem_data = ov_en ? ov_val : mem_fn(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Abstract model of the stage's architectural state.
    logic [31:0] m_pc, m_instr, m_pcout, m_cnt, m_fetched;
    logic        m_valid;
    bit          m_live = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_pc = 32'h0; m_instr = NOP; m_pcout = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
            m_live = 1;
        end else if (branch_taken) begin
            m_pcout = m_pc;
            m_pc    = branch_target & 32'hFFFF_FFFC;
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            m_fetched = ov_en ? ov_val : mem_fn(m_pc);
            if (if_id_load) begin
                m_instr = m_fetched; m_pcout = m_pc; m_valid = 1'b1; m_cnt = m_cnt + 1;
            end
            if (pc_load) m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            check("model_imem_addr", imem_addr, m_pc);
            check("model_instruction", instruction, m_instr);
            check("model_pc_out", pc_out, m_pcout);
            check("model_valid_out", {31'h0, valid_out}, {31'h0, m_valid});
            check("model_fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic ctl(input logic pl, input logic il, input logic bt, input logic [31:0] tg);
        pc_load = pl; if_id_load = il; branch_taken = bt; branch_target = tg;
    endtask

    initial begin
        reset = 1'b1; ov_en = 1'b1; ov_val = 32'hDEAD_BEEF;
        ctl(1, 1, 0, 32'h0);
        step(2);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_instruction", instruction, NOP);
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_count", fetch_count, 32'h0);

        // Sequential fetch
        reset = 1'b0; ov_en = 1'b0;
        step(1);
        check("seq1_instr", instruction, 32'h0030_2083);
        check("seq1_pc_out", pc_out, 32'h0);
        check("seq1_valid", {31'h0, valid_out}, 32'h1);
        step(1);
        check("seq2_instr", instruction, 32'h0070_2103);
        check("seq2_pc_out", pc_out, 32'h4);
        check("seq2_imem_addr", imem_addr, 32'h8);
        check("seq2_count", fetch_count, 32'd2);

        // Stall for three edges at PC=8
        ctl(0, 0, 0, 32'h0);
        step(3);
        check("stall_imem_addr", imem_addr, 32'h8);
        check("stall_instr", instruction, 32'h0070_2103);
        check("stall_count", fetch_count, 32'd2);
        ctl(1, 1, 0, 32'h0);
        step(1);
        check("release_pc_out", pc_out, 32'h8);
        check("release_instr", instruction, mem_fn(32'h8));
        check("release_count", fetch_count, 32'd3);
        step(1);
        check("pre_branch_pc", imem_addr, 32'h10);

        // Redirect at PC=0x10
        ctl(1, 1, 1, 32'h40);
        step(1);
        check("br_imem_addr", imem_addr, 32'h40);
        check("br_valid", {31'h0, valid_out}, 32'h0);
        check("br_instr", instruction, NOP);
        check("br_pc_out", pc_out, 32'h10);
        check("br_count", fetch_count, 32'd4);
        ctl(1, 1, 0, 32'h0);
        step(1);
        check("br_next_pc_out", pc_out, 32'h40);
        check("br_next_valid", {31'h0, valid_out}, 32'h1);

        // Back-to-back redirects: last target wins
        ctl(1, 1, 1, 32'h100);
        step(1);
        ctl(1, 1, 1, 32'h200);
        step(1);
        check("b2b_imem_addr", imem_addr, 32'h200);
        check("b2b_pc_out", pc_out, 32'h100);
        check("b2b_valid", {31'h0, valid_out}, 32'h0);
        ctl(1, 1, 0, 32'h0);
        step(1);

        // Redirect during stall with misaligned target
        ctl(0, 0, 1, 32'h23);
        step(1);
        check("stallbr_imem_addr", imem_addr, 32'h20);
        check("stallbr_valid", {31'h0, valid_out}, 32'h0);
        check("stallbr_instr", instruction, NOP);
        ctl(1, 1, 0, 32'h0);
        step(1);
        check("stallbr_next_pc_out", pc_out, 32'h20);

        // Unusual control mixes, applied independently
        ctl(1, 0, 0, 32'h0);
        step(1);
        ctl(0, 1, 0, 32'h0);
        step(2);
        for (int i = 0; i < 24; i++) begin
            ctl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 5) == 0), $urandom);
            step(1);
        end

        // Wrap at the top of the address space
        ctl(1, 1, 1, 32'hFFFF_FFFC);
        step(1);
        check("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        ctl(1, 1, 0, 32'h0);
        step(1);
        check("wrap_imem_addr", imem_addr, 32'h0);
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);

        // Reset during a stall
        ctl(0, 0, 0, 32'h0);
        step(1);
        reset = 1'b1; ov_en = 1'b1; ov_val = 32'hCAFE_F00D;
        step(1);
        check("midrst_imem_addr", imem_addr, 32'h0);
        check("midrst_instr", instruction, NOP);
        check("midrst_pc_out", pc_out, 32'h0);
        check("midrst_valid", {31'h0, valid_out}, 32'h0);
        check("midrst_count", fetch_count, 32'h0);
        reset = 1'b0; ov_en = 1'b0;
        ctl(1, 1, 0, 32'h0);
        step(1);
        check("after_rst_instr", instruction, 32'h0030_2083);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
